operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- In-order RV32 single-issue pipeline stage between decode and execute: register file read, operand selection, load-use bubble insertion, and the OF->EX pipeline register.
- Consumes the registered forwarding packet from the dependency controller and the write-back port from WB.
- Produces the upstream stall for the IF and IF/OF registers.

Parameters:
- XLEN, 32, data/PC width
- NREGS, 32, architectural registers (x0 hardwired zero)
- AW, 5, register address width
- CTRLW, 16, opaque decode-control bus width, passed through to EX

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_pc  in  XLEN  instruction PC
- in_instr  in  32  raw instruction
- in_rs1  in  AW  source register 1
- in_rs2  in  AW  source register 2
- in_uses_rs1  in  1  instruction reads rs1
- in_uses_rs2  in  1  instruction reads rs2
- in_rd  in  AW  destination register
- in_rd_wen  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- in_imm  in  XLEN  decoded immediate
- in_ctrl  in  CTRLW  decode control
- fwd_rs1_enable  in  1  forward valid for rs1
- fwd_rs1_data  in  XLEN  forwarded rs1 value
- fwd_rs2_enable  in  1  forward valid for rs2
- fwd_rs2_data  in  XLEN  forwarded rs2 value
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  AW  EX destination register
- wb_enable  in  1  register-file write enable
- wb_addr  in  AW  write address
- wb_data  in  XLEN  write data
- flush  in  1  branch/jump redirect; kill the OF instruction
- stall_in  in  1  downstream stall; hold the output register
- stall_up  out  1  hold IF and IF/OF registers
- out_valid  out  1  EX packet valid
- out_pc  out  XLEN  registered PC
- out_instr  out  32  registered instruction; NOP 0x00000013 on bubble
- out_rs1_data  out  XLEN  selected operand 1
- out_rs2_data  out  XLEN  selected operand 2
- out_rd  out  AW  registered rd
- out_rd_wen  out  1  registered write enable; 0 on bubble
- out_is_load  out  1  registered load flag
- out_imm  out  XLEN  registered immediate
- out_ctrl  out  CTRLW  registered control; 0 on bubble
- bubble_count  out  16  saturating count of load-use bubbles inserted

Behaviour:
- Reset (resetn low, asynchronous):
  - all register-file entries 0
  - out_valid 0, out_instr 0x00000013, all other outputs 0
  - state RUN, bubble_count 0
- Register file:
  - NREGS x XLEN flops, write on posedge when wb_enable && wb_addr != 0.
  - Writes to x0 are dropped.
  - Read is combinational, write-first: if wb_enable && wb_addr == rs && rs != 0, the read returns wb_data.
- Operand select, per source, priority order:
  - rs == 0 -> 0
  - else fwd_rsN_enable -> fwd_rsN_data
  - else register-file read (with bypass)
- Hazard is combinational:
  - hazard = in_valid && ex_valid && ex_is_load && ex_rd != 0 && ((in_uses_rs1 && in_rs1 == ex_rd) || (in_uses_rs2 && in_rs2 == ex_rd))
- FSM, states RUN and BUBBLE, evaluated each posedge with priority flush > stall_in > hazard:
  - flush: output register loads a bubble (valid 0, NOP, rd_wen 0, ctrl 0); state goes to RUN; stall_up = 0.
  - stall_in && !flush: output register holds, state holds, stall_up = 1.
  - RUN, hazard: output loads a bubble, state goes to BUBBLE, stall_up = 1, bubble_count increments (saturates at 0xFFFF).
  - RUN, no hazard: output captures the in_* fields and selected operands (out_valid = in_valid), stay in RUN, stall_up = 0.
  - BUBBLE: capture unconditionally and ignore hazard, because the load has moved to MEM and is covered by forwarding. Return to RUN; stall_up = 0.
- Output latency: one cycle from capture to out_*.
- A stalled instruction re-selects operands every cycle, so a write-back landing during a stall is picked up.
- Simultaneous flush and hazard: flush wins, no bubble is counted, state goes to RUN.
- Reset mid-BUBBLE returns the FSM to RUN.
- Unknown values on in_* while in_valid = 0 must not propagate into out_valid or out_rd_wen.

Test Plan:
- Write-first bypass: write x5 = 0xDEADBEEF; next cycle issue add reading rs1 = x5 with wb_enable, wb_addr = 5, wb_data = 0x12345678 in the same cycle -> out_rs1_data = 0x12345678 one cycle later.
- x0 handling: wb writes x0 = 0xFFFFFFFF; then read rs1 = x0 with fwd_rs1_enable = 1 and fwd_rs1_data = 0xAAAA -> out_rs1_data = 0.
- Load-use: ex_valid = 1, ex_is_load = 1, ex_rd = 7; in_rs2 = 7 with in_uses_rs2 = 1 ->
  - stall_up = 1 for exactly one cycle
  - bubble emitted (out_valid = 0, out_instr = 0x00000013)
  - the instruction issues the following cycle
  - bubble_count = 1
- Forward priority: fwd_rs2_enable = 1 with fwd_rs2_data = 0x55 while the register file holds x3 = 0x99 and rs2 = 3 -> out_rs2_data = 0x55.
- Downstream stall: hold stall_in = 1 for 3 cycles -> out_* is unchanged for all 3 cycles and stall_up = 1; capture resumes in the cycle after release.
- Flush over hazard: assert flush together with a load-use hazard -> bubble output, stall_up = 0, state RUN, bubble_count unchanged. Assert resetn low mid-stall -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage for an in-order RV32 pipeline: register file, operand
// selection, load-use bubble insertion and the OF->EX pipeline register.
module operand_fetch_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int CTRLW = 16
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_instr,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic             in_uses_rs1,
    input  logic             in_uses_rs2,
    input  logic [AW-1:0]    in_rd,
    input  logic             in_rd_wen,
    input  logic             in_is_load,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [CTRLW-1:0] in_ctrl,

    input  logic             fwd_rs1_enable,
    input  logic [XLEN-1:0]  fwd_rs1_data,
    input  logic             fwd_rs2_enable,
    input  logic [XLEN-1:0]  fwd_rs2_data,

    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [AW-1:0]    ex_rd,

    input  logic             wb_enable,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,

    input  logic             flush,
    input  logic             stall_in,
    output logic             stall_up,

    output logic             out_valid,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_rs1_data,
    output logic [XLEN-1:0]  out_rs2_data,
    output logic [AW-1:0]    out_rd,
    output logic             out_rd_wen,
    output logic             out_is_load,
    output logic [XLEN-1:0]  out_imm,
    output logic [CTRLW-1:0] out_ctrl,
    output logic [15:0]      bubble_count
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN,
        BUBBLE
    } state_t;

    state_t state;
    state_t state_next;

    logic [XLEN-1:0] rf [NREGS];

    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic            hazard;
    logic            load_capture;
    logic            load_bubble;
    logic            count_inc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_enable && wb_addr != '0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // x0 beats forwarding, forwarding beats the (write-first) register file.
    function automatic logic [XLEN-1:0] select_operand(
        input logic [AW-1:0]   rs,
        input logic            fwd_en,
        input logic [XLEN-1:0] fwd_data
    );
        if (rs == '0) begin
            select_operand = '0;
        end else if (fwd_en) begin
            select_operand = fwd_data;
        end else if (wb_enable && wb_addr == rs) begin
            select_operand = wb_data;
        end else begin
            select_operand = rf[rs];
        end
    endfunction

    always_comb begin
        rs1_value = select_operand(in_rs1, fwd_rs1_enable, fwd_rs1_data);
        rs2_value = select_operand(in_rs2, fwd_rs2_enable, fwd_rs2_data);
    end

    assign hazard = in_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((in_uses_rs1 && in_rs1 == ex_rd) ||
                     (in_uses_rs2 && in_rs2 == ex_rd));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // In BUBBLE the load has reached MEM and is forwarded, so hazard is ignored.
    always_comb begin
        state_next   = state;
        stall_up     = 1'b0;
        load_capture = 1'b0;
        load_bubble  = 1'b0;
        count_inc    = 1'b0;
        if (flush) begin
            load_bubble = 1'b1;
            state_next  = RUN;
        end else if (stall_in) begin
            stall_up = 1'b1;
        end else if (state == RUN && hazard) begin
            load_bubble = 1'b1;
            state_next  = BUBBLE;
            stall_up    = 1'b1;
            count_inc   = 1'b1;
        end else begin
            load_capture = 1'b1;
            state_next   = RUN;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_instr    <= NOP_INSTR;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
            out_rd_wen   <= 1'b0;
            out_is_load  <= 1'b0;
            out_imm      <= '0;
            out_ctrl     <= '0;
        end else if (load_bubble) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_instr    <= NOP_INSTR;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
            out_rd_wen   <= 1'b0;
            out_is_load  <= 1'b0;
            out_imm      <= '0;
            out_ctrl     <= '0;
        end else if (load_capture) begin
            // Gate with in_valid so junk on an empty slot never reaches EX.
            out_valid    <= in_valid;
            out_pc       <= in_pc;
            out_instr    <= in_instr;
            out_rs1_data <= rs1_value;
            out_rs2_data <= rs2_value;
            out_rd       <= in_rd;
            out_rd_wen   <= in_valid && in_rd_wen;
            out_is_load  <= in_is_load;
            out_imm      <= in_imm;
            out_ctrl     <= in_ctrl;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bubble_count <= '0;
        end else if (count_inc && bubble_count != 16'hFFFF) begin
            bubble_count <= bubble_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed literal cases followed
// by randomized traffic compared against a behavioural model every cycle.
module tb_operand_fetch_stage;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int CTRLW = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic [XLEN-1:0]  in_pc;
    logic [31:0]      in_instr;
    logic [AW-1:0]    in_rs1;
    logic [AW-1:0]    in_rs2;
    logic             in_uses_rs1;
    logic             in_uses_rs2;
    logic [AW-1:0]    in_rd;
    logic             in_rd_wen;
    logic             in_is_load;
    logic [XLEN-1:0]  in_imm;
    logic [CTRLW-1:0] in_ctrl;
    logic             fwd_rs1_enable;
    logic [XLEN-1:0]  fwd_rs1_data;
    logic             fwd_rs2_enable;
    logic [XLEN-1:0]  fwd_rs2_data;
    logic             ex_valid;
    logic             ex_is_load;
    logic [AW-1:0]    ex_rd;
    logic             wb_enable;
    logic [AW-1:0]    wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             stall_in;
    logic             stall_up;
    logic             out_valid;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_instr;
    logic [XLEN-1:0]  out_rs1_data;
    logic [XLEN-1:0]  out_rs2_data;
    logic [AW-1:0]    out_rd;
    logic             out_rd_wen;
    logic             out_is_load;
    logic [XLEN-1:0]  out_imm;
    logic [CTRLW-1:0] out_ctrl;
    logic [15:0]      bubble_count;

    always #5 clk = ~clk;

    operand_fetch_stage #(.XLEN(XLEN), .NREGS(32), .AW(AW), .CTRLW(CTRLW)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
        .in_imm(in_imm), .in_ctrl(in_ctrl),
        .fwd_rs1_enable(fwd_rs1_enable), .fwd_rs1_data(fwd_rs1_data),
        .fwd_rs2_enable(fwd_rs2_enable), .fwd_rs2_data(fwd_rs2_data),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .stall_in(stall_in), .stall_up(stall_up),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_is_load(out_is_load),
        .out_imm(out_imm), .out_ctrl(out_ctrl), .bubble_count(bubble_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: architectural registers, "just inserted a bubble" flag,
    // bubble counter and the packet EX must see after the next edge.
    logic [31:0] m_rf [32];
    bit          m_bubble;
    int          m_count;
    logic        e_valid;
    logic [31:0] e_pc, e_instr, e_rs1, e_rs2, e_imm;
    logic [4:0]  e_rd;
    logic        e_rd_wen, e_is_load;
    logic [15:0] e_ctrl;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] m_operand(input logic [4:0] rs, input logic fen,
                                              input logic [31:0] fd);
        if (rs == 5'd0) return 32'd0;
        if (fen) return fd;
        if (wb_enable && wb_addr == rs) return wb_data;
        return m_rf[rs];
    endfunction

    function automatic logic m_hazard();
        return in_valid && ex_valid && ex_is_load && ex_rd != 5'd0 &&
               ((in_uses_rs1 && in_rs1 == ex_rd) || (in_uses_rs2 && in_rs2 == ex_rd));
    endfunction

    function automatic logic m_stall();
        if (flush) return 1'b0;
        if (stall_in) return 1'b1;
        return !m_bubble && m_hazard();
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_bubble = 1'b0;
        m_count  = 0;
        e_valid = 1'b0; e_pc = '0; e_instr = NOP; e_rs1 = '0; e_rs2 = '0;
        e_imm = '0; e_rd = '0; e_rd_wen = 1'b0; e_is_load = 1'b0; e_ctrl = '0;
    endtask

    task automatic modelBubble();
        e_valid = 1'b0; e_instr = NOP; e_rd_wen = 1'b0; e_ctrl = '0;
    endtask

    task automatic modelStep();
        logic [31:0] o1, o2;
        o1 = m_operand(in_rs1, fwd_rs1_enable, fwd_rs1_data);
        o2 = m_operand(in_rs2, fwd_rs2_enable, fwd_rs2_data);
        if (flush) begin
            modelBubble();
            m_bubble = 1'b0;
        end else if (stall_in) begin
            // packet and bubble flag both hold
        end else if (!m_bubble && m_hazard()) begin
            modelBubble();
            m_bubble = 1'b1;
            if (m_count < 65535) m_count++;
        end else begin
            e_valid = in_valid; e_pc = in_pc; e_instr = in_instr;
            e_rs1 = o1; e_rs2 = o2; e_rd = in_rd;
            e_rd_wen = in_valid && in_rd_wen; e_is_load = in_is_load;
            e_imm = in_imm; e_ctrl = in_ctrl;
            m_bubble = 1'b0;
        end
        if (wb_enable && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
    endtask

    task automatic checkAll();
        checkOutput("stall_up", 32'(stall_up), 32'(m_stall()));
        checkOutput("out_valid", 32'(out_valid), 32'(e_valid));
        checkOutput("out_instr", out_instr, e_instr);
        checkOutput("out_rd_wen", 32'(out_rd_wen), 32'(e_rd_wen));
        checkOutput("out_ctrl", 32'(out_ctrl), 32'(e_ctrl));
        checkOutput("bubble_count", 32'(bubble_count), 32'(m_count));
        if (e_valid) begin
            checkOutput("out_pc", out_pc, e_pc);
            checkOutput("out_rs1_data", out_rs1_data, e_rs1);
            checkOutput("out_rs2_data", out_rs2_data, e_rs2);
            checkOutput("out_rd", 32'(out_rd), 32'(e_rd));
            checkOutput("out_is_load", 32'(out_is_load), 32'(e_is_load));
            checkOutput("out_imm", out_imm, e_imm);
        end
    endtask

    task automatic idleInputs();
        in_valid = 1'b0; in_pc = '0; in_instr = NOP; in_rs1 = '0; in_rs2 = '0;
        in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_rd = '0; in_rd_wen = 1'b0;
        in_is_load = 1'b0; in_imm = '0; in_ctrl = '0;
        fwd_rs1_enable = 1'b0; fwd_rs1_data = '0; fwd_rs2_enable = 1'b0; fwd_rs2_data = '0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
        wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; stall_in = 1'b0;
    endtask

    task automatic applyStimulus();
        in_valid       = ($urandom_range(0, 9) < 8);
        in_pc          = $urandom;
        in_instr       = $urandom;
        in_rs1         = 5'($urandom_range(0, 7));
        in_rs2         = 5'($urandom_range(0, 7));
        in_uses_rs1    = 1'($urandom_range(0, 1));
        in_uses_rs2    = 1'($urandom_range(0, 1));
        in_rd          = 5'($urandom_range(0, 31));
        in_rd_wen      = 1'($urandom_range(0, 1));
        in_is_load     = 1'($urandom_range(0, 1));
        in_imm         = $urandom;
        in_ctrl        = 16'($urandom);
        fwd_rs1_enable = ($urandom_range(0, 3) == 0);
        fwd_rs1_data   = $urandom;
        fwd_rs2_enable = ($urandom_range(0, 3) == 0);
        fwd_rs2_data   = $urandom;
        ex_valid       = 1'($urandom_range(0, 1));
        ex_is_load     = 1'($urandom_range(0, 1));
        ex_rd          = 5'($urandom_range(0, 7));
        wb_enable      = 1'($urandom_range(0, 1));
        wb_addr        = 5'($urandom_range(0, 7));
        wb_data        = $urandom;
        flush          = ($urandom_range(0, 9) == 0);
        stall_in       = ($urandom_range(0, 6) == 0);
    endtask

    // Model advances with the inputs the DUT is about to sample, then the edge.
    task automatic tick();
        modelStep();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idleInputs();
        resetn = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_instr", out_instr, 32'h0000_0013);
        checkOutput("reset_count", 32'(bubble_count), 32'd0);
        checkOutput("reset_pc", out_pc, 32'd0);
        @(posedge clk);
        #2;
        resetn = 1'b1;

        // write-first bypass
        wb_enable = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        idleInputs();
        in_valid = 1'b1; in_rs1 = 5'd5; in_uses_rs1 = 1'b1; in_rd = 5'd1; in_rd_wen = 1'b1;
        in_instr = 32'h0002_80B3;
        wb_enable = 1'b1; wb_addr = 5'd5; wb_data = 32'h12345678;
        tick();
        checkOutput("bypass_rs1", out_rs1_data, 32'h12345678);
        checkOutput("bypass_valid", 32'(out_valid), 32'd1);

        // x0 ignores both writes and forwarding
        idleInputs();
        wb_enable = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        tick();
        idleInputs();
        in_valid = 1'b1; fwd_rs1_enable = 1'b1; fwd_rs1_data = 32'h0000AAAA;
        tick();
        checkOutput("x0_rs1", out_rs1_data, 32'd0);

        // forwarding beats the register file
        idleInputs();
        wb_enable = 1'b1; wb_addr = 5'd3; wb_data = 32'h99;
        tick();
        idleInputs();
        in_valid = 1'b1; in_rs2 = 5'd3; in_uses_rs2 = 1'b1;
        fwd_rs2_enable = 1'b1; fwd_rs2_data = 32'h55;
        tick();
        checkOutput("fwd_rs2", out_rs2_data, 32'h55);
        idleInputs();
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd3; in_uses_rs2 = 1'b1;
        tick();
        checkOutput("rf_rs2", out_rs2_data, 32'h99);
        checkOutput("rf_rs1", out_rs1_data, 32'h12345678);

        // load-use bubble
        idleInputs();
        in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'h0073_8333;
        in_rs2 = 5'd7; in_uses_rs2 = 1'b1; in_rd = 5'd6; in_rd_wen = 1'b1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        #1;
        checkOutput("lu_stall_first", 32'(stall_up), 32'd1);
        tick();
        checkOutput("lu_bubble_valid", 32'(out_valid), 32'd0);
        checkOutput("lu_bubble_instr", out_instr, 32'h0000_0013);
        checkOutput("lu_count", 32'(bubble_count), 32'd1);
        checkOutput("lu_stall_second", 32'(stall_up), 32'd0);
        tick();
        checkOutput("lu_issue_valid", 32'(out_valid), 32'd1);
        checkOutput("lu_issue_pc", out_pc, 32'h200);
        checkOutput("lu_issue_rd", 32'(out_rd), 32'd6);

        // downstream stall holds the packet for three cycles
        idleInputs();
        in_valid = 1'b1; in_pc = 32'h300;
        tick();
        checkOutput("ds_capture", out_pc, 32'h300);
        for (int k = 0; k < 3; k++) begin
            stall_in = 1'b1;
            in_pc = 32'h304 + 32'(4 * k);
            #1;
            checkOutput("ds_stall_up", 32'(stall_up), 32'd1);
            tick();
            checkOutput("ds_hold_pc", out_pc, 32'h300);
            checkOutput("ds_hold_valid", 32'(out_valid), 32'd1);
        end
        stall_in = 1'b0; in_pc = 32'h310;
        #1;
        checkOutput("ds_release_stall", 32'(stall_up), 32'd0);
        tick();
        checkOutput("ds_resume_pc", out_pc, 32'h310);

        // flush beats a simultaneous hazard
        idleInputs();
        in_valid = 1'b1; in_rs1 = 5'd9; in_uses_rs1 = 1'b1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9;
        flush = 1'b1;
        #1;
        checkOutput("fl_stall_up", 32'(stall_up), 32'd0);
        tick();
        checkOutput("fl_valid", 32'(out_valid), 32'd0);
        checkOutput("fl_instr", out_instr, 32'h0000_0013);
        checkOutput("fl_count", 32'(bubble_count), 32'd1);
        flush = 1'b0;
        #1;
        checkOutput("fl_state_run", 32'(stall_up), 32'd1);
        tick();
        checkOutput("fl_count_next", 32'(bubble_count), 32'd2);

        // reset while in BUBBLE and stalled
        stall_in = 1'b1;
        #1;
        checkOutput("rs_stall_up", 32'(stall_up), 32'd1);
        resetn = 1'b0;
        modelReset();
        #1;
        checkOutput("rs_valid", 32'(out_valid), 32'd0);
        checkOutput("rs_instr", out_instr, 32'h0000_0013);
        checkOutput("rs_count", 32'(bubble_count), 32'd0);
        checkOutput("rs_pc", out_pc, 32'd0);
        resetn = 1'b1;
        stall_in = 1'b0;
        #1;
        checkOutput("rs_state_run", 32'(stall_up), 32'd1);
        idleInputs();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            #1;
            checkAll();
            tick();
        end
        idleInputs();
        #1;
        checkAll();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
